// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-memory read bus between the fetch stage and instruction memory.
//   imem_req   fetch -> mem   read request (high while fetching)
//   imem_addr  fetch -> mem   read address (current fetch PC)
//   imem_rdy   mem -> fetch   imem_data valid this cycle
//   imem_data  mem -> fetch   instruction word read at imem_addr
// Modports: master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdy,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdy,
      output imem_data
   );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch stage plus IF/ID pipeline register. Owns the PC, reads instruction
// memory and latches the fetched word together with its PC+2 into IF/ID.
// Bubbles are injected on hazard NOP, memory wait, halt and redirect.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-high reset
//   imem                fetch_ctrl_if.master: imem_req/imem_addr out,
//                       imem_rdy/imem_data in
//   pc_stall_i          hold PC and IF/ID (hazard detection)
//   nop_i               load a bubble into IF/ID this cycle
//   redirect_i          taken branch/jump: load redirect_pc_i, squash IF/ID
//   redirect_pc_i[15:0] redirect target (bit0 is always cleared)
//   pc_o[15:0]          current fetch PC
//   if_id_instr_o[15:0] instruction handed to decode
//   if_id_pc_plus2_o    PC+2 of if_id_instr_o
//   if_id_valid_o       1 = real instruction, 0 = bubble
//   halted_o            HALT fetched, fetch stopped until redirect/reset
//   err_o               sticky misaligned-redirect flag
//
// Build option
//   FETCH_ALIGN_CHK_EN  when defined, a redirect with an odd target sets err_o
//                       (sticky until rst). Otherwise err_o is tied low.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [15:0] PC_RESET  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic               clk,
   input  logic               rst,
   fetch_ctrl_if.master       imem,
   input  logic               pc_stall_i,
   input  logic               nop_i,
   input  logic               redirect_i,
   input  logic [15:0]        redirect_pc_i,
   output logic [15:0]        pc_o,
   output logic [15:0]        if_id_instr_o,
   output logic [15:0]        if_id_pc_plus2_o,
   output logic               if_id_valid_o,
   output logic               halted_o,
   output logic               err_o
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] instr_q;
   logic [15:0] pc_plus2_q;
   logic        valid_q;
   logic        halted_q;
   logic        req_q;

   // Modulo-2^16 increment: 16'hFFFE wraps to 16'h0000 silently.
   logic [15:0] pc_plus2_d;
   assign pc_plus2_d = pc_q + 16'd2;

   // Opcode 5'b00000 is HALT.
   logic is_halt_d;
   assign is_halt_d = (imem.imem_data[15:11] == 5'b00000);

   // Branch targets are halfword aligned; bit0 is dropped on load.
   logic [15:0] redirect_aligned_d;
   assign redirect_aligned_d = {redirect_pc_i[15:1], 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= PC_RESET;
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= 16'h0000;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         req_q      <= 1'b1;
      end else if (redirect_i) begin
         // Redirect wins over everything, including HALT and WAIT.
         pc_q     <= redirect_aligned_d;
         instr_q  <= NOP_INSTR;
         valid_q  <= 1'b0;
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
         req_q    <= 1'b1;
      end else if (pc_stall_i) begin
         // Full freeze, unless hazard logic also asks for a bubble.
         if (nop_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
         end
      end else if (state_q == ST_HALT) begin
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (!imem.imem_rdy) begin
         // Address stays on the bus; no new request is issued.
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         state_q <= ST_WAIT;
      end else if (nop_i) begin
         // Word is consumed from memory but dropped.
         pc_q    <= pc_plus2_d;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         pc_q       <= pc_plus2_d;
         instr_q    <= imem.imem_data;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= 1'b1;
         if (is_halt_d) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
            req_q    <= 1'b0;
         end else begin
            state_q <= ST_RUN;
         end
      end
   end

`ifdef FETCH_ALIGN_CHK_EN
   logic err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (redirect_i && redirect_pc_i[0]) begin
         err_q <= 1'b1;
      end
   end
   assign err_o = err_q;
`else
   // Bit0 of the target is intentionally ignored in this build.
   logic unused_redirect_bit0;
   assign unused_redirect_bit0 = redirect_pc_i[0];
   assign err_o = 1'b0;
`endif

   assign imem.imem_req    = req_q;
   assign imem.imem_addr   = pc_q;
   assign pc_o             = pc_q;
   assign if_id_instr_o    = instr_q;
   assign if_id_pc_plus2_o = pc_plus2_q;
   assign if_id_valid_o    = valid_q;
   assign halted_o         = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after the next rising edge.
// Honours FETCH_ALIGN_CHK_EN for the err_o expectation.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_stall_i = 1'b0;
   logic        nop_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [15:0] redirect_pc_i = 16'h0000;
   logic [15:0] pc_o;
   logic [15:0] if_id_instr_o;
   logic [15:0] if_id_pc_plus2_o;
   logic        if_id_valid_o;
   logic        halted_o;
   logic        err_o;

   logic [15:0] mem [0:127];

   int n_cmp = 0;
   int n_err = 0;

`ifdef FETCH_ALIGN_CHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   fetch_ctrl_if ifc ();

   assign ifc.imem_data = mem[ifc.imem_addr[7:1]];

   fetch_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .imem             (ifc.master),
      .pc_stall_i       (pc_stall_i),
      .nop_i            (nop_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .pc_o             (pc_o),
      .if_id_instr_o    (if_id_instr_o),
      .if_id_pc_plus2_o (if_id_pc_plus2_o),
      .if_id_valid_o    (if_id_valid_o),
      .halted_o         (halted_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full IF/ID + PC + status check, one line per transaction.
   task automatic chk_all(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                          input logic [15:0] pp2, input logic valid, input logic halted,
                          input logic req);
      chk({tag, ".pc"}, pc_o, pc);
      chk({tag, ".addr"}, ifc.imem_addr, pc);
      chk({tag, ".instr"}, if_id_instr_o, instr);
      chk({tag, ".pp2"}, if_id_pc_plus2_o, pp2);
      chk({tag, ".valid"}, {15'd0, if_id_valid_o}, {15'd0, valid});
      chk({tag, ".halted"}, {15'd0, halted_o}, {15'd0, halted});
      chk({tag, ".req"}, {15'd0, ifc.imem_req}, {15'd0, req});
      $display("%0t %s pc=%h instr=%h pp2=%h v=%0b h=%0b req=%0b err=%0b", $time, tag,
               pc_o, if_id_instr_o, if_id_pc_plus2_o, if_id_valid_o, halted_o,
               ifc.imem_req, err_o);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'hF000 | 16'(i);
      mem[0]  = 16'h4001;  // addr 0x0000
      mem[1]  = 16'h1111;  // addr 0x0002
      mem[2]  = 16'h2222;  // addr 0x0004
      mem[3]  = 16'h3333;  // addr 0x0006
      mem[4]  = 16'h0000;  // addr 0x0008: HALT
      mem[16] = 16'h5555;  // addr 0x0020
      mem[32] = 16'h6666;  // addr 0x0040
      mem[127] = 16'h7777; // addr 0xFFFE
      ifc.imem_rdy = 1'b1;

      // Reset values (asynchronous, checked before any clock edge)
      #1 rst = 1'b1;
      #1;
      chk_all("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("reset.err", {15'd0, err_o}, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: first fetch
      step(); chk_all("fetch0", 16'h0002, 16'h4001, 16'h0002, 1'b1, 1'b0, 1'b1);
      step(); chk_all("fetch2", 16'h0004, 16'h1111, 16'h0004, 1'b1, 1'b0, 1'b1);

      // 3: memory wait at Pc=4
      ifc.imem_rdy = 1'b0;
      step(); chk_all("wait1", 16'h0004, 16'h0800, 16'h0004, 1'b0, 1'b0, 1'b1);
      step(); chk_all("wait2", 16'h0004, 16'h0800, 16'h0004, 1'b0, 1'b0, 1'b1);
      ifc.imem_rdy = 1'b1;
      step(); chk_all("wait_done", 16'h0006, 16'h2222, 16'h0006, 1'b1, 1'b0, 1'b1);

      // 2: stall at Pc=6, then stall with NOP
      pc_stall_i = 1'b1;
      step(); chk_all("stall1", 16'h0006, 16'h2222, 16'h0006, 1'b1, 1'b0, 1'b1);
      step(); chk_all("stall2", 16'h0006, 16'h2222, 16'h0006, 1'b1, 1'b0, 1'b1);
      step(); chk_all("stall3", 16'h0006, 16'h2222, 16'h0006, 1'b1, 1'b0, 1'b1);
      nop_i = 1'b1;
      step(); chk_all("stall_nop", 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0, 1'b1);

      // NOP alone: word at 6 dropped, Pc advances
      pc_stall_i = 1'b0;
      step(); chk_all("nop_drop", 16'h0008, 16'h0800, 16'h0006, 1'b0, 1'b0, 1'b1);
      nop_i = 1'b0;

      // 5: HALT at Pc=8
      step(); chk_all("halt_load", 16'h000A, 16'h0000, 16'h000A, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(); chk_all("halt_hold", 16'h000A, 16'h0800, 16'h000A, 1'b0, 1'b1, 1'b0);
      end
      redirect_i = 1'b1; redirect_pc_i = 16'h0020;
      step(); chk_all("halt_redir", 16'h0020, 16'h0800, 16'h000A, 1'b0, 1'b0, 1'b1);
      redirect_i = 1'b0;
      step(); chk_all("resume", 16'h0022, 16'h5555, 16'h0022, 1'b1, 1'b0, 1'b1);

      // 4: redirect beats stall and memory wait
      redirect_i = 1'b1; redirect_pc_i = 16'h0040; pc_stall_i = 1'b1; ifc.imem_rdy = 1'b0;
      step(); chk_all("redir_prio", 16'h0040, 16'h0800, 16'h0022, 1'b0, 1'b0, 1'b1);
      redirect_i = 1'b0; pc_stall_i = 1'b0; ifc.imem_rdy = 1'b1;
      step(); chk_all("redir_run", 16'h0042, 16'h6666, 16'h0042, 1'b1, 1'b0, 1'b1);

      // 6: wrap at 0xFFFE
      redirect_i = 1'b1; redirect_pc_i = 16'hFFFE;
      step(); chk_all("redir_fffe", 16'hFFFE, 16'h0800, 16'h0042, 1'b0, 1'b0, 1'b1);
      redirect_i = 1'b0;
      step(); chk_all("wrap", 16'h0000, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b1);
      chk("wrap.err", {15'd0, err_o}, 16'h0000);

      // Misaligned redirect: bit0 dropped, err per build option
      redirect_i = 1'b1; redirect_pc_i = 16'h0013;
      step(); chk_all("redir_odd", 16'h0012, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("redir_odd.err", {15'd0, err_o}, {15'd0, ERR_EXP});
      redirect_i = 1'b0; ifc.imem_rdy = 1'b0;
      step(); chk_all("odd_wait", 16'h0012, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("err_sticky", {15'd0, err_o}, {15'd0, ERR_EXP});

      // Reset mid-WAIT: immediate return to reset values
      #2 rst = 1'b1;
      #1;
      chk_all("rst_midwait", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("rst_midwait.err", {15'd0, err_o}, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0; ifc.imem_rdy = 1'b1;
      step(); chk_all("post_rst", 16'h0002, 16'h4001, 16'h0002, 1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
